// File: rtl/traffic_conflict_monitor_if.sv
// traffic_conflict_monitor_if: observed lamp signals in, watchdog fault status out
interface traffic_conflict_monitor_if;
  logic traffic_red;
  logic traffic_yellow;
  logic traffic_green;
  logic pedestrian_walk;
  logic pedestrian_dont_walk;
  logic emergency;
  logic fault_clear;
  logic force_emergency;
  logic fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;
  modport master (
    output traffic_red, traffic_yellow, traffic_green, pedestrian_walk, pedestrian_dont_walk,
           emergency, fault_clear,
    input  force_emergency, fault, fault_code, fault_count
  );
  modport slave (
    input  traffic_red, traffic_yellow, traffic_green, pedestrian_walk, pedestrian_dont_walk,
           emergency, fault_clear,
    output force_emergency, fault, fault_code, fault_count
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: latches the first illegal lamp combination or sequence and forces emergency
module traffic_conflict_monitor #(
  parameter int FILTER_CYCLES  = 2,
  parameter int MIN_YELLOW     = 5,
  parameter int MAX_DARK       = 8,
  parameter int STARTUP_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  traffic_conflict_monitor_if.slave bus
);
  typedef enum logic [1:0] {STARTUP, ARMED, TRIPPED} state_t;
  typedef enum logic [2:0] {C_DARK, C_RED, C_YEL, C_GRN, C_MULTI} cls_t;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int DW = $clog2(MAX_DARK + 1);
  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_CYCLES);
  localparam logic [FW-1:0] F_TRIP = FW'(FILTER_CYCLES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW);
  localparam logic [DW-1:0] D_MAX = DW'(MAX_DARK);
  localparam logic [SW-1:0] S_END = SW'(STARTUP_CYCLES - 1);
  state_t state, state_n;
  cls_t cls, prev_cls;
  logic [FW-1:0] flt [1:3];
  logic [YW-1:0] yel_cnt;
  logic [DW-1:0] dark_cnt;
  logic [SW-1:0] st_cnt;
  logic [6:1] raw, trip;
  logic [2:0] code, fault_code;
  logic [7:0] fault_count;
  logic clr;
  always_comb begin
    cls = {bus.traffic_red, bus.traffic_yellow, bus.traffic_green} == 3'b000 ? C_DARK :
          {bus.traffic_red, bus.traffic_yellow, bus.traffic_green} == 3'b100 ? C_RED :
          {bus.traffic_red, bus.traffic_yellow, bus.traffic_green} == 3'b010 ? C_YEL :
          {bus.traffic_red, bus.traffic_yellow, bus.traffic_green} == 3'b001 ? C_GRN : C_MULTI;
    raw[1] = cls == C_MULTI;
    raw[2] = bus.pedestrian_walk && (bus.traffic_green || bus.traffic_yellow);
    raw[3] = bus.pedestrian_walk == bus.pedestrian_dont_walk;
    raw[4] = prev_cls == C_GRN && cls == C_RED;
    raw[5] = prev_cls == C_YEL && cls == C_RED && yel_cnt < Y_MAX;
    raw[6] = cls == C_DARK && !bus.emergency && dark_cnt == D_MAX;
    trip = raw;
    for (int i = 1; i <= 3; i++) trip[i] = raw[i] && flt[i] == F_TRIP;
    code = trip[1] ? 3'd1 : trip[2] ? 3'd2 : trip[3] ? 3'd3 :
           trip[4] ? 3'd4 : trip[5] ? 3'd5 : trip[6] ? 3'd6 : 3'd0;
    clr = state == TRIPPED && bus.fault_clear && raw == '0;
    state_n = state;
    if (state == STARTUP && st_cnt == S_END) state_n = ARMED;
    if (state == ARMED && trip != '0) state_n = TRIPPED;
    if (clr) state_n = ARMED;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= STARTUP;
      prev_cls <= C_DARK;
      for (int i = 1; i <= 3; i++) flt[i] <= '0;
      yel_cnt <= '0;
      dark_cnt <= '0;
      st_cnt <= '0;
      fault_code <= '0;
      fault_count <= '0;
    end else begin
      state <= state_n;
      prev_cls <= cls;
      st_cnt <= state == STARTUP ? st_cnt + SW'(1) : st_cnt;
      for (int i = 1; i <= 3; i++)
        flt[i] <= (state == STARTUP || clr || !raw[i]) ? '0 : flt[i] == F_MAX ? flt[i] : flt[i] + FW'(1);
      yel_cnt <= (clr || cls != C_YEL) ? '0 : yel_cnt == Y_MAX ? yel_cnt : yel_cnt + YW'(1);
      dark_cnt <= (clr || cls != C_DARK || bus.emergency) ? '0 : dark_cnt == D_MAX ? dark_cnt : dark_cnt + DW'(1);
      if (state == ARMED && trip != '0) begin
        fault_code <= code;
        fault_count <= fault_count == 8'hff ? fault_count : fault_count + 8'd1;
      end else if (clr) fault_code <= '0;
    end
  end
  assign bus.fault = state == TRIPPED;
  assign bus.force_emergency = state == TRIPPED;
  assign bus.fault_code = fault_code;
  assign bus.fault_count = fault_count;
endmodule
